master_slave_dff: RTL and testbench
===================================

Name: master_slave_dff

Overview:
- Positive-edge-triggered D flip-flop built as two cascaded level-sensitive latches (master, slave). WIDTH-bit vector.
- Leaf storage element for the digital-design lab tree. Instantiated by top-level wrappers that drive D and Clock from stimulus.
- Internal latch structure is explicit in the RTL, not a behavioural always @(posedge) register, so the master/slave handoff can be observed in waveforms.

Parameters:
- WIDTH, 1, number of independent flip-flop bits.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into Q by reset.

Ports:
- Clock  input  1  single clock. Master latch is transparent while Clock=0; slave latch is transparent while Clock=1.
- Reset  input  1  synchronous, active-high reset. Only takes effect at a rising edge of Clock.
- D  input  WIDTH  data in.
- Enable  input  1  load enable. When 0, Q holds its value across edges.
- Q  output  WIDTH  slave latch output (flip-flop output).
- Qn  output  WIDTH  bitwise complement of Q.
- Qm  output  WIDTH  master latch output (debug/observation).

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Master input mux: m_in = Reset ? RESET_VALUE : (Enable ? D : Q). Reset has priority over Enable.
- Master latch: Qm follows m_in while Clock=0. Qm freezes at the rising edge and holds while Clock=1.
- Slave latch: Q follows Qm while Clock=1. Q holds while Clock=0.
- Net effect: Q updates only at a rising edge of Clock, to the m_in value present just before that edge. Latency is 1 edge. No change of Q at the falling edge.
- D changes while Clock=1 never reach Q until the next rising edge. A D pulse that starts and ends within one Clock-high phase is lost entirely.
- D changes while Clock=0 are visible on Qm immediately, and on Q only after the rising edge.
- Reset asserted mid-cycle with no rising edge: Q is unchanged and Qm shows RESET_VALUE.
- Reset released before a rising edge: that edge loads D (or holds Q if Enable=0).
- Power-up: Q and Qm are X until the first rising edge with Reset=1, or with Enable=1 and D known. The bench applies Reset for at least 1 edge.
- Qn = ~Q combinationally at all times, including the X state.
- Each bit is independent. No cross-bit logic.
- Latches are coded as level-sensitive always blocks with complete enables, one generate loop over WIDTH.
- Simulation `timescale 1ns/10ps. Zero-delay model.

Optional Feature:
- Macro MS_DFF_SCAN_EN.
- When defined: add ports ScanEn (input 1) and ScanIn (input WIDTH). m_in priority is Reset > ScanEn (loads ScanIn) > Enable (loads D) > hold.
- When not defined: ports ScanEn and ScanIn are absent; mux as above.

Test Plan:
- Reset: D=1, Enable=1, Reset=1 for 1 rising edge -> Q=0, Qn=1. Then Reset=0 -> next edge gives Q=1.
- Edge capture: Clock period 20ns, D=1 for 50ns then 0 -> Q rises at the first rising edge after reset and falls at the first rising edge after D=0. Q never changes at a falling edge.
- High-phase glitch: D pulses 0->1->0 for 5ns entirely inside a Clock=1 phase -> Q stays 0. Qm stays 0.
- Low-phase tracking: D toggles during Clock=0 -> Qm follows D, Q unchanged until the rising edge, then Q = last D.
- Enable hold: Q=1, Enable=0, D=0 for 3 edges -> Q stays 1. Enable=1 -> next edge Q=0.
- Reset mid-phase: Reset pulse 5ns during Clock=1 with no edge -> Q unchanged. With MS_DFF_SCAN_EN defined: ScanEn=1, ScanIn=1, D=0 -> Q=1 at the next edge.

Source files
------------

// File: rtl/master_slave_dff.sv
// WIDTH-bit positive-edge D flip-flop built from explicit master/slave latches.
// Optional scan-load path enabled by defining MS_DFF_SCAN_EN (adds ScanEn/ScanIn).
`timescale 1ns/10ps

module master_slave_dff #(
   parameter int                 WIDTH       = 1,
   parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}}
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] D,
   input  logic             Enable,
`ifdef MS_DFF_SCAN_EN
   input  logic             ScanEn,
   input  logic [WIDTH-1:0] ScanIn,
`endif
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qn,
   output logic [WIDTH-1:0] Qm
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic m_in_d;
         logic qm_q;
         logic q_q;

         // Hold recirculates the slave output, so Enable=0 keeps Q across edges.
         always_comb begin
            m_in_d = q_q;
            if (Reset) begin
               m_in_d = RESET_VALUE[gi];
            end
`ifdef MS_DFF_SCAN_EN
            else if (ScanEn) begin
               m_in_d = ScanIn[gi];
            end
`endif
            else if (Enable) begin
               m_in_d = D[gi];
            end
         end

         // Master is open while Clock is low and freezes at the rising edge.
         always_latch begin
            if (!Clock) begin
               qm_q <= m_in_d;
            end
         end

         // Slave is open while Clock is high, passing the frozen master value.
         always_latch begin
            if (Clock) begin
               q_q <= qm_q;
            end
         end

         assign Qm[gi] = qm_q;
         assign Q[gi]  = q_q;
      end
   endgenerate

   assign Qn = ~Q;

endmodule

// File: tb/tb_master_slave_dff.sv
// Directed bench for master_slave_dff: stimulus queues expectations, a monitor
// process pops and compares them against the sampled Q/Qn/Qm.
`timescale 1ns/10ps

module tb_master_slave_dff;

   localparam int         W  = 4;
   localparam logic [3:0] RV = 4'b0101;

   logic         clk;
   logic         rst;
   logic         en;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic [W-1:0] qn;
   logic [W-1:0] qm;
`ifdef MS_DFF_SCAN_EN
   logic         se;
   logic [W-1:0] si;
`endif

   master_slave_dff #(
      .WIDTH       (W),
      .RESET_VALUE (RV)
   ) dut (
      .Clock  (clk),
      .Reset  (rst),
      .D      (d),
      .Enable (en),
`ifdef MS_DFF_SCAN_EN
      .ScanEn (se),
      .ScanIn (si),
`endif
      .Q      (q),
      .Qn     (qn),
      .Qm     (qm)
   );

   typedef struct {
      string      name;
      logic [3:0] exp_q;
      logic [3:0] exp_qm;
      logic [3:0] act_q;
      logic [3:0] act_qn;
      logic [3:0] act_qm;
   } sample_t;

   sample_t exp_fifo[$];
   event    sample_ev;
   int      checks   = 0;
   int      failures = 0;

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   task automatic goto(input int t);
      #(t - int'($time));
   endtask

   // Queue the expected response together with the DUT outputs present now.
   task automatic expect_now(input string name, input logic [3:0] eq, input logic [3:0] eqm);
      sample_t s;
      s.name   = name;
      s.exp_q  = eq;
      s.exp_qm = eqm;
      s.act_q  = q;
      s.act_qn = qn;
      s.act_qm = qm;
      exp_fifo.push_back(s);
      ->sample_ev;
   endtask

   initial begin : monitor
      sample_t s;
      forever begin
         @(sample_ev);
         while (exp_fifo.size() != 0) begin
            s = exp_fifo.pop_front();
            checks++;
            if (s.act_q !== s.exp_q) begin
               failures++;
               $display("FAIL %s Q: got %b expected %b", s.name, s.act_q, s.exp_q);
            end
            checks++;
            if (s.act_qn !== ~s.exp_q) begin
               failures++;
               $display("FAIL %s Qn: got %b expected %b", s.name, s.act_qn, ~s.exp_q);
            end
            checks++;
            if (s.act_qm !== s.exp_qm) begin
               failures++;
               $display("FAIL %s Qm: got %b expected %b", s.name, s.act_qm, s.exp_qm);
            end
            $display("t=%0t %s Q=%b Qn=%b Qm=%b (exp Q=%b Qm=%b)",
                     $time, s.name, s.act_q, s.act_qn, s.act_qm, s.exp_q, s.exp_qm);
         end
      end
   end

   initial begin : stimulus
      rst = 1'b1;
      en  = 1'b1;
      d   = 4'b1111;
`ifdef MS_DFF_SCAN_EN
      se  = 1'b0;
      si  = 4'b0000;
`endif
      // Reset edge at 10 ns, then D=1111 captured at 30 ns.
      goto(11);  expect_now("reset",          RV,      RV);
      goto(12);  rst = 1'b0;
      goto(15);  expect_now("high_frozen",    RV,      RV);
      goto(21);  expect_now("fall_no_change", RV,      4'b1111);
      goto(31);  expect_now("capture_rise",   4'b1111, 4'b1111);
      goto(35);  d = 4'b0110;
      goto(39);  expect_now("high_d_change",  4'b1111, 4'b1111);
      goto(41);  expect_now("low_track",      4'b1111, 4'b0110);
      goto(51);  expect_now("capture_next",   4'b0110, 4'b0110);
      // Glitch wholly inside the 50-60 ns high phase.
      goto(54);  d = 4'b1001;
      goto(57);  expect_now("glitch_in_high", 4'b0110, 4'b0110);
      goto(59);  d = 4'b0110;
      goto(61);  expect_now("glitch_gone_qm", 4'b0110, 4'b0110);
      goto(71);  expect_now("glitch_lost",    4'b0110, 4'b0110);
      // D toggles during the 80-90 ns low phase.
      goto(81);  d = 4'b0011;
      goto(82);  expect_now("low_toggle_a",   4'b0110, 4'b0011);
      goto(84);  d = 4'b1100;
      goto(85);  expect_now("low_toggle_b",   4'b0110, 4'b1100);
      goto(86);  d = 4'b1000;
      goto(91);  expect_now("low_toggle_rise",4'b1000, 4'b1000);
      // Enable low across three edges.
      goto(92);  en = 1'b0; d = 4'b0000;
      goto(101); expect_now("hold_low_qm",    4'b1000, 4'b1000);
      goto(111); expect_now("hold_edge1",     4'b1000, 4'b1000);
      goto(131); expect_now("hold_edge2",     4'b1000, 4'b1000);
      goto(151); expect_now("hold_edge3",     4'b1000, 4'b1000);
      goto(152); en = 1'b1;
      goto(161); expect_now("enable_low_qm",  4'b1000, 4'b0000);
      goto(171); expect_now("enable_load",    4'b0000, 4'b0000);
      goto(172); d = 4'b1110;
      goto(191); expect_now("load_1110",      4'b1110, 4'b1110);
      // Reset pulse inside a high phase, then inside a low phase.
      goto(194); rst = 1'b1;
      goto(196); expect_now("rst_high_phase", 4'b1110, 4'b1110);
      goto(199); rst = 1'b0;
      goto(201); expect_now("after_rst_pulse",4'b1110, 4'b1110);
      goto(203); rst = 1'b1;
      goto(204); expect_now("rst_low_qm",     4'b1110, RV);
      goto(206); rst = 1'b0; d = 4'b0011;
      goto(207); expect_now("rst_release_qm", 4'b1110, 4'b0011);
      goto(211); expect_now("rst_release_edge",4'b0011, 4'b0011);
      // Reset beats Enable=0 hold.
      goto(215); rst = 1'b1; en = 1'b0;
      goto(231); expect_now("rst_over_hold",  RV,      RV);
      goto(232); rst = 1'b0; en = 1'b1; d = 4'b1111;
`ifdef MS_DFF_SCAN_EN
      goto(235); se = 1'b1; si = 4'b1011; d = 4'b0000;
      goto(251); expect_now("scan_load",      4'b1011, 4'b1011);
      goto(252); rst = 1'b1;
      goto(271); expect_now("rst_over_scan",  RV,      RV);
      goto(272); rst = 1'b0; se = 1'b0; d = 4'b1111;
      goto(291); expect_now("scan_off",       4'b1111, 4'b1111);
`else
      goto(251); expect_now("enable_reload",  4'b1111, 4'b1111);
`endif
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
